regfile_layer_ctrl: RTL and testbench

Parametrised control/status register bank for one accelerator layer engine, generalising the fixed per-layer register files. It has a configurable base address and configurable counts of config and status registers. Config registers are double-buffered: the bus writes staging copies, and the engine sees a shadow copy that is committed only on START, so the next layer can be programmed while the current one runs. It adds a self-clearing START, a BUSY/DONE/ERR status word with write-1-to-clear, an interrupt, and a registered read path with a valid strobe.

---
 rtl/regfile_layer_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_regfile_layer_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_layer_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_layer_ctrl
//
// Control/status register bank for one accelerator layer engine.
//
// The bus side sees a small register window starting at BASE_ADDR:
//   offset 0                : CTRL   (bit0 START, write-1 / reads 0; bit1 IRQ_EN)
//   offset 1                : STATUS (bit0 BUSY RO; bit1 DONE W1C; bit2 ERR W1C)
//   offset 2 .. 1+NUM_CFG   : CFG staging words, read/write
//   next NUM_STAT offsets   : STAT words, live view of stat_in, read-only
// Anything else in the address space reads 0 and ignores writes.
//
// Config words are double-buffered. The bus only ever writes the staging copy;
// the engine sees the shadow copy on cfg_out, which is loaded from staging in
// one shot when a START is accepted. This lets software program layer N+1
// while layer N is still running without disturbing the engine.
//
// Event ordering within one clock:
//   1. core_done is applied first (clears BUSY, sets DONE) if BUSY was set.
//   2. A START write is then judged against the post-done BUSY value, so a
//      start landing on the same edge as completion is accepted cleanly.
//   3. Set events on DONE/ERR beat a simultaneous write-1-to-clear.
//
// Reads are registered: rd_en sampled at an edge loads read_data from the
// register contents as they were before that edge, and read_valid pulses for
// exactly that one cycle. read_data holds its value between reads.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   wr_en        bus write strobe
//   rd_en        bus read strobe
//   addr         bus address (ADDR_W)
//   write_data   bus write data (DATA_W)
//   read_data    registered read data (DATA_W)
//   read_valid   one-cycle strobe qualifying read_data
//   cfg_out      committed shadow config, CFG[i] at [i*DATA_W +: DATA_W]
//   start_pulse  one-cycle engine start
//   core_done    engine completion pulse
//   stat_in      live engine status words, STAT[j] at [j*DATA_W +: DATA_W]
//   irq          level interrupt, IRQ_EN & (DONE | ERR), registered
// -----------------------------------------------------------------------------
module regfile_layer_ctrl #(
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 14,
  parameter int unsigned BASE_ADDR = 'h400,
  parameter int          NUM_CFG   = 8,
  parameter int          NUM_STAT  = 4
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                wr_en,
  input  logic                                                rd_en,
  input  logic [ADDR_W-1:0]                                   addr,
  input  logic [DATA_W-1:0]                                   write_data,
  output logic [DATA_W-1:0]                                   read_data,
  output logic                                                read_valid,
  output logic [NUM_CFG*DATA_W-1:0]                           cfg_out,
  output logic                                                start_pulse,
  input  logic                                                core_done,
  input  logic [((NUM_STAT > 0) ? NUM_STAT : 1)*DATA_W-1:0]   stat_in,
  output logic                                                irq
);

  // ---------------------------------------------------------------------------
  // Address map
  // ---------------------------------------------------------------------------
  localparam int              NUM_REGS   = 2 + NUM_CFG + NUM_STAT;
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] NREGS_A  = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] OFF_CTRL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] OFF_STAT = ADDR_W'(1);

  logic [ADDR_W-1:0] offset;
  logic              addr_hit;
  logic              sel_ctrl;
  logic              sel_status;

  // The subtraction wraps for addresses below the base, so the lower-bound
  // compare is needed in addition to the window-size compare.
  assign offset     = addr - BASE_A;
  assign addr_hit   = (addr >= BASE_A) && (offset < NREGS_A);
  assign sel_ctrl   = addr_hit && (offset == OFF_CTRL);
  assign sel_status = addr_hit && (offset == OFF_STAT);

  // ---------------------------------------------------------------------------
  // Control/status state
  // ---------------------------------------------------------------------------
  logic irq_en_reg,      irq_en_next;
  logic busy_reg,        busy_next;
  logic done_reg,        done_next;
  logic err_reg,         err_next;
  logic start_pulse_reg, start_acc;
  logic irq_reg,         irq_next;

  logic done_evt;
  logic busy_after_done;
  logic start_req;
  logic start_err;
  logic ctrl_wr;
  logic status_wr;

  always_comb begin
    ctrl_wr         = wr_en & sel_ctrl;
    status_wr       = wr_en & sel_status;

    // Completion is applied before the start request is judged.
    done_evt        = core_done & busy_reg;
    busy_after_done = busy_reg & ~core_done;

    start_req       = ctrl_wr & write_data[0];
    start_acc       = start_req & ~busy_after_done;
    start_err       = start_req &  busy_after_done;

    irq_en_next     = ctrl_wr ? write_data[1] : irq_en_reg;
    busy_next       = start_acc | busy_after_done;

    // Clear first, then set, so a same-cycle set event wins over W1C.
    done_next = done_reg;
    if (status_wr && write_data[1]) begin
      done_next = 1'b0;
    end
    if (done_evt) begin
      done_next = 1'b1;
    end

    err_next = err_reg;
    if (status_wr && write_data[2]) begin
      err_next = 1'b0;
    end
    if (start_err) begin
      err_next = 1'b1;
    end

    // irq is registered from the next-state values so it tracks the flag
    // registers exactly while coming straight off a flop.
    irq_next = irq_en_next & (done_next | err_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      start_pulse_reg <= 1'b0;
      irq_reg         <= 1'b0;
    end else begin
      irq_en_reg      <= irq_en_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
      start_pulse_reg <= start_acc;
      irq_reg         <= irq_next;
    end
  end

  assign start_pulse = start_pulse_reg;
  assign irq         = irq_reg;

  // ---------------------------------------------------------------------------
  // Readable register image, indexed by offset
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] reg_words [NUM_REGS];
  logic [DATA_W-1:0] ctrl_word;
  logic [DATA_W-1:0] status_word;

  always_comb begin
    // START always reads back as 0; only IRQ_EN is visible in CTRL.
    ctrl_word         = '0;
    ctrl_word[1]      = irq_en_reg;
    status_word       = '0;
    status_word[2:0]  = {err_reg, done_reg, busy_reg};
  end

  assign reg_words[0] = ctrl_word;
  assign reg_words[1] = status_word;

  // ---------------------------------------------------------------------------
  // Config words: staging (bus side) and shadow (engine side)
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
      logic [DATA_W-1:0] stg_reg;
      logic [DATA_W-1:0] shd_reg;
      logic              cfg_wr;

      assign cfg_wr = wr_en && addr_hit && (offset == ADDR_W'(2 + gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stg_reg <= '0;
        end else if (cfg_wr) begin
          stg_reg <= write_data;
        end
      end

      // Shadow only moves on an accepted START; CFG writes while busy
      // therefore land in staging and wait for the next start.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shd_reg <= '0;
        end else if (start_acc) begin
          shd_reg <= stg_reg;
        end
      end

      assign reg_words[2 + gi]              = stg_reg;
      assign cfg_out[gi*DATA_W +: DATA_W]   = shd_reg;
    end

    for (gi = 0; gi < NUM_STAT; gi++) begin : g_stat
      assign reg_words[2 + NUM_CFG + gi] = stat_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Registered read path
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] read_data_reg;
  logic              read_valid_reg;

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addr_hit && (offset == ADDR_W'(k))) begin
        rd_mux = reg_words[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_reg  <= '0;
      read_valid_reg <= 1'b0;
    end else begin
      read_valid_reg <= rd_en;
      if (rd_en) begin
        read_data_reg <= rd_mux;
      end
    end
  end

  assign read_data  = read_data_reg;
  assign read_valid = read_valid_reg;

endmodule

// File: tb/tb_regfile_layer_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_layer_ctrl (default parameters).
// A behavioural model of the register bank is stepped on every clock edge and
// a compare process checks all outputs against it on every falling edge.
// A directed sequence with hand-computed literal expectations pins the model,
// followed by randomized bus/engine traffic.
// -----------------------------------------------------------------------------
module tb_regfile_layer_ctrl;

  localparam int          DW    = 16;
  localparam int          AW    = 14;
  localparam int          BASEI = 'h400;
  localparam logic [13:0] BASE  = 14'h400;
  localparam int          NCFG  = 8;
  localparam int          NSTAT = 4;
  localparam int          NREG  = 2 + NCFG + NSTAT;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wr_en = 1'b0;
  logic            rd_en = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic [DW-1:0]   write_data = '0;
  logic [DW-1:0]   read_data;
  logic            read_valid;
  logic [NCFG*DW-1:0] cfg_out;
  logic            start_pulse;
  logic            core_done = 1'b0;
  logic [NSTAT*DW-1:0] stat_in = '0;
  logic            irq;

  int total = 0;
  int bad   = 0;
  int txn_n = 0;

  regfile_layer_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASEI), .NUM_CFG(NCFG), .NUM_STAT(NSTAT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .write_data(write_data), .read_data(read_data), .read_valid(read_valid),
    .cfg_out(cfg_out), .start_pulse(start_pulse), .core_done(core_done),
    .stat_in(stat_in), .irq(irq)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [15:0] m_stg [NCFG];
  logic [15:0] m_shd [NCFG];
  logic        m_irq_en, m_busy, m_done, m_err;
  logic [15:0] m_rd_data;
  logic        m_rd_valid, m_start, m_irq;

  function automatic int map_off(input logic [13:0] a);
    int ai;
    ai = int'(a);
    if (ai < BASEI || ai - BASEI >= NREG) return -1;
    return ai - BASEI;
  endfunction

  function automatic logic [15:0] model_read(input int o);
    if (o == 0) return {14'd0, m_irq_en, 1'b0};
    if (o == 1) return {13'd0, m_err, m_done, m_busy};
    if (o >= 2 && o < 2 + NCFG) return m_stg[o-2];
    if (o >= 2 + NCFG && o < NREG) return stat_in[(o-2-NCFG)*16 +: 16];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCFG; i++) begin
      m_stg[i] = 16'h0;
      m_shd[i] = 16'h0;
    end
    m_irq_en = 0; m_busy = 0; m_done = 0; m_err = 0;
    m_rd_data = 16'h0; m_rd_valid = 0; m_start = 0; m_irq = 0;
  endtask

  task automatic model_step();
    int  o;
    logic done_set, err_set, go;
    o = map_off(addr);
    done_set = 0; err_set = 0; go = 0;
    // reads see the state before this edge
    if (rd_en) m_rd_data = model_read(o);
    m_rd_valid = rd_en;
    // engine completion is handled before any start request
    if (core_done && m_busy) begin
      m_busy = 0; m_done = 1; done_set = 1;
    end
    if (wr_en && o >= 0) begin
      if (o == 0) begin
        m_irq_en = write_data[1];
        if (write_data[0]) begin
          if (m_busy) begin m_err = 1; err_set = 1; end
          else go = 1;
        end
      end else if (o == 1) begin
        if (write_data[1] && !done_set) m_done = 0;
        if (write_data[2] && !err_set)  m_err  = 0;
      end else if (o < 2 + NCFG) begin
        m_stg[o-2] = write_data;
      end
    end
    if (go) begin
      for (int i = 0; i < NCFG; i++) m_shd[i] = m_stg[i];
      m_busy = 1;
    end
    m_start = go;
    m_irq = m_irq_en && (m_done || m_err);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [NCFG*DW-1:0] exp_cfg;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCFG; i++) exp_cfg[i*16 +: 16] = m_shd[i];
      chk("m_read_data",   {112'd0, read_data},   {112'd0, m_rd_data});
      chk("m_read_valid",  {127'd0, read_valid},  {127'd0, m_rd_valid});
      chk("m_start_pulse", {127'd0, start_pulse}, {127'd0, m_start});
      chk("m_irq",         {127'd0, irq},         {127'd0, m_irq});
      chk("m_cfg_out",     cfg_out,               exp_cfg);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input logic w, input logic r, input logic [13:0] a,
                      input logic [15:0] d, input logic cd);
    wr_en = w; rd_en = r; addr = a; write_data = d; core_done = cd;
    @(negedge clk);
    txn_n++;
    $display("txn %0d wr=%0b rd=%0b addr=%h wdata=%h done=%0b -> rdata=%h rvalid=%0b start=%0b irq=%0b",
             txn_n, w, r, a, d, cd, read_data, read_valid, start_pulse, irq);
  endtask

  task automatic wr(input int o, input logic [15:0] d);
    step(1'b1, 1'b0, BASE + 14'(o), d, 1'b0);
  endtask

  task automatic idle_done();
    step(1'b0, 1'b0, BASE, 16'h0, 1'b1);
  endtask

  task automatic rd_chk(input string name, input int o, input logic [15:0] exp);
    step(1'b0, 1'b1, BASE + 14'(o), 16'h0, 1'b0);
    chk(name, {112'd0, read_data}, {112'd0, exp});
    chk({name, "_valid"}, {127'd0, read_valid}, 128'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] w3;
    logic [13:0] ra;
    int sel;
    for (int j = 0; j < NSTAT; j++) stat_in[j*16 +: 16] = 16'hA000 + 16'(j);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_read_data",   {112'd0, read_data}, 128'd0);
    chk("rst_read_valid",  {127'd0, read_valid}, 128'd0);
    chk("rst_start_pulse", {127'd0, start_pulse}, 128'd0);
    chk("rst_irq",         {127'd0, irq}, 128'd0);
    chk("rst_cfg_out",     cfg_out, 128'd0);
    rst = 1'b0;

    // read the whole window plus one past the end
    for (int o = 0; o <= NREG; o++) begin
      if (o >= 2 + NCFG && o < NREG) rd_chk("rd_default", o, 16'hA000 + 16'(o - 2 - NCFG));
      else                           rd_chk("rd_default", o, 16'h0000);
    end
    step(1'b0, 1'b0, BASE, 16'h0, 1'b0);
    chk("rd_valid_drop", {127'd0, read_valid}, 128'd0);

    // program and start
    wr(5, 16'hBEEF);
    wr(0, 16'h0001);
    w3 = cfg_out[3*16 +: 16];
    chk("start_pulse_hi", {127'd0, start_pulse}, 128'd1);
    chk("cfg3_beef", {112'd0, w3}, {112'd0, 16'hBEEF});
    rd_chk("status_busy", 1, 16'h0001);
    chk("start_pulse_lo", {127'd0, start_pulse}, 128'd0);

    // reprogram while busy, restart -> error
    wr(5, 16'h1234);
    wr(0, 16'h0001);
    w3 = cfg_out[3*16 +: 16];
    chk("cfg3_held", {112'd0, w3}, {112'd0, 16'hBEEF});
    chk("no_pulse_busy", {127'd0, start_pulse}, 128'd0);
    rd_chk("status_err", 1, 16'h0005);
    idle_done();
    rd_chk("status_done_err", 1, 16'h0006);
    wr(1, 16'h0006);
    rd_chk("status_clr", 1, 16'h0000);

    // interrupt path
    wr(0, 16'h0002);
    wr(0, 16'h0003);
    chk("irq_lo_running", {127'd0, irq}, 128'd0);
    idle_done();
    chk("irq_after_done", {127'd0, irq}, 128'd1);
    wr(0, 16'h0003);
    step(1'b1, 1'b0, BASE + 14'd1, 16'h0002, 1'b1);
    chk("irq_set_wins", {127'd0, irq}, 128'd1);
    rd_chk("status_done_kept", 1, 16'h0002);

    // same-cycle completion and start
    wr(0, 16'h0003);
    wr(5, 16'h5A5A);
    wr(1, 16'h0006);
    chk("irq_cleared", {127'd0, irq}, 128'd0);
    step(1'b1, 1'b0, BASE, 16'h0003, 1'b1);
    w3 = cfg_out[3*16 +: 16];
    chk("sim_start_pulse", {127'd0, start_pulse}, 128'd1);
    chk("sim_cfg3", {112'd0, w3}, {112'd0, 16'h5A5A});
    chk("sim_irq", {127'd0, irq}, 128'd1);
    rd_chk("sim_status", 1, 16'h0003);

    // asynchronous reset mid-run
    #2 rst = 1'b1;
    #1;
    chk("arst_read_data",   {112'd0, read_data}, 128'd0);
    chk("arst_read_valid",  {127'd0, read_valid}, 128'd0);
    chk("arst_start_pulse", {127'd0, start_pulse}, 128'd0);
    chk("arst_irq",         {127'd0, irq}, 128'd0);
    chk("arst_cfg_out",     cfg_out, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("post_rst_status", 1, 16'h0000);
    rd_chk("post_rst_ctrl", 0, 16'h0000);
    rd_chk("post_rst_cfg3", 5, 16'h0000);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        #3 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      for (int j = 0; j < NSTAT; j++) stat_in[j*16 +: 16] = 16'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel < 2)      ra = BASE + 14'($urandom_range(0, 1));
      else if (sel < 8) ra = BASE + 14'($urandom_range(0, NREG + 1));
      else if (sel < 9) ra = BASE - 14'($urandom_range(1, 3));
      else              ra = 14'($urandom);
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), ra,
           16'($urandom), ($urandom_range(0, 3) == 0));
    end
    step(1'b0, 1'b0, BASE, 16'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
